// File: rtl/bt656_luma_extractor.sv
// BT.656 front end: finds FF 00 00 XY timing codes, validates XY and emits exactly
// ACTIVE_PIXELS luma bytes per accepted active line into the line FIFO.
module bt656_luma_extractor #(
  parameter int unsigned ACTIVE_PIXELS = 720,
  parameter logic [7:0]  BLACK_Y       = 8'h10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] bt656_data,
  input  logic       fifo_full,
  output logic [7:0] data_out,
  output logic       write,
  output logic       field,
  output logic       vblank,
  output logic       sav_pulse,
  output logic       eav_pulse,
  output logic       line_dropped,
  output logic       protect_err,
  output logic       short_line
);

  localparam int unsigned LINE_BYTES = 2 * ACTIVE_PIXELS;
  localparam int unsigned CNT_W      = $clog2(LINE_BYTES);
  localparam int unsigned REM_W      = $clog2(ACTIVE_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LINE_BYTES - 1);
  localparam logic [REM_W-1:0] FULL_LINE = REM_W'(ACTIVE_PIXELS);

  typedef enum logic [1:0] {SEARCH, ACTIVE, PAD} state_t;
  typedef enum logic [1:0] {PRE_NONE, PRE_FF, PRE_FF00, PRE_FF0000} pre_t;

  state_t           state_reg, state_next;
  pre_t             pre_reg, pre_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [REM_W-1:0] rem_reg, rem_next;

  logic [7:0] data_next;
  logic       write_next, field_next, vblank_next;
  logic       sav_next, eav_next, dropped_next, perr_next, short_next;

  logic xy_f, xy_v, xy_h, xy_ok, is_xy, code_ok, code_sav, code_eav;

  assign xy_f  = bt656_data[6];
  assign xy_v  = bt656_data[5];
  assign xy_h  = bt656_data[4];
  assign xy_ok = bt656_data[7]
               & (bt656_data[3] == (xy_v ^ xy_h))
               & (bt656_data[2] == (xy_f ^ xy_h))
               & (bt656_data[1] == (xy_f ^ xy_v))
               & (bt656_data[0] == (xy_f ^ xy_v ^ xy_h));
  assign is_xy    = (pre_reg == PRE_FF0000);
  assign code_ok  = is_xy & xy_ok;
  assign code_sav = code_ok & ~xy_h;
  assign code_eav = code_ok & xy_h;

  // A new FF always restarts the preamble, even mid-line or as the XY byte.
  always_comb begin
    pre_next = PRE_NONE;
    if (bt656_data == 8'hFF)
      pre_next = PRE_FF;
    else if (bt656_data == 8'h00 && pre_reg == PRE_FF)
      pre_next = PRE_FF00;
    else if (bt656_data == 8'h00 && pre_reg == PRE_FF00)
      pre_next = PRE_FF0000;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rem_next     = rem_reg;
    data_next    = data_out;
    write_next   = 1'b0;
    field_next   = field;
    vblank_next  = vblank;
    sav_next     = code_sav;
    eav_next     = code_eav;
    perr_next    = is_xy & ~xy_ok;
    dropped_next = 1'b0;
    short_next   = 1'b0;

    if (code_ok)
      vblank_next = xy_v;
    if (code_sav)
      field_next = xy_f;

    unique case (state_reg)
      SEARCH: begin
        if (code_sav && !xy_v) begin
          if (fifo_full) begin
            dropped_next = 1'b1;
          end else begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end
        end
      end
      ACTIVE: begin
        if (bt656_data == 8'hFF) begin
          // Pad the rest of the line so the FIFO slot stays aligned.
          short_next = 1'b1;
          state_next = PAD;
          rem_next   = FULL_LINE - REM_W'(cnt_reg >> 1);
        end else begin
          if (cnt_reg[0]) begin
            write_next = 1'b1;
            data_next  = bt656_data;
          end
          if (cnt_reg == LAST_BYTE)
            state_next = SEARCH;
          else
            cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PAD: begin
        write_next = 1'b1;
        data_next  = BLACK_Y;
        rem_next   = rem_reg - REM_W'(1);
        if (rem_reg == REM_W'(1))
          state_next = SEARCH;
        if (code_sav && !xy_v)
          dropped_next = 1'b1;
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= SEARCH;
      pre_reg      <= PRE_NONE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      data_out     <= '0;
      write        <= 1'b0;
      field        <= 1'b0;
      vblank       <= 1'b0;
      sav_pulse    <= 1'b0;
      eav_pulse    <= 1'b0;
      line_dropped <= 1'b0;
      protect_err  <= 1'b0;
      short_line   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      cnt_reg      <= cnt_next;
      rem_reg      <= rem_next;
      data_out     <= data_next;
      write        <= write_next;
      field        <= field_next;
      vblank       <= vblank_next;
      sav_pulse    <= sav_next;
      eav_pulse    <= eav_next;
      line_dropped <= dropped_next;
      protect_err  <= perr_next;
      short_line   <= short_next;
    end
  end

endmodule

// File: doc/bt656_luma_extractor.md
Name: bt656_luma_extractor

Overview:
- Upstream stage of the 5-line cross-clock line FIFO, in the BT.656 pixel clock domain.
- Parses the raw 8-bit BT.656 byte stream: detects FF 00 00 XY timing codes, checks XY protection bits, and tracks field/vblank.
- Emits exactly ACTIVE_PIXELS luma (Y) bytes per active line as a write strobe and data, sized to the FIFO's 720-byte line slots.
- Guarantees line alignment downstream: every accepted line produces exactly ACTIVE_PIXELS writes.

Parameters:
ACTIVE_PIXELS, 720, luma samples per active line; active bytes per line = 2*ACTIVE_PIXELS (Cb Y Cr Y order).
BLACK_Y, 8'h10, pad value for lines truncated by a premature timing code.

Ports:
clock  in  1  BT.656 byte clock (27 MHz); all logic on its rising edge.
reset  in  1  asynchronous, active-high; clears all state.
bt656_data  in  8  raw BT.656 byte, one per clock.
fifo_full  in  1  full flag from the line FIFO, sampled only at SAV.
data_out  out  8  luma byte to the FIFO data_in.
write  out  1  one-cycle write strobe to the FIFO write input.
field  out  1  F bit of the last valid SAV.
vblank  out  1  V bit of the last valid timing code.
sav_pulse  out  1  one-cycle pulse on a valid SAV.
eav_pulse  out  1  one-cycle pulse on a valid EAV.
line_dropped  out  1  one-cycle pulse when an active SAV is not accepted.
protect_err  out  1  one-cycle pulse on an XY byte failing the protection check.
short_line  out  1  one-cycle pulse when a timing preamble interrupts an active line.

Behaviour:
- Reset: all outputs 0, data_out=0, state SEARCH, preamble detector and counters cleared. Reset mid-line discards the partial line with no padding.
- Preamble detector:
  - Tracks consecutive bytes FF,00,00 and runs independently of state.
  - The byte after the preamble is XY: F=XY[6], V=XY[5], H=XY[4].
  - XY is valid iff XY[7]=1, XY[3]=V^H, XY[2]=F^H, XY[1]=F^V, XY[0]=F^V^H.
  - Invalid XY: protect_err pulses and the code is ignored (no state, field or vblank change).
- Valid XY:
  - H=1 is EAV: eav_pulse; vblank<=V.
  - H=0 is SAV: sav_pulse; field<=F; vblank<=V.
- All outputs are registered. A pulse asserts in the cycle after the XY byte is sampled.
- States:
  - SEARCH: wait for SAV.
    - SAV with V=1: stay in SEARCH.
    - SAV with V=0 and fifo_full=0: go to ACTIVE, byte counter = 0.
    - SAV with V=0 and fifo_full=1: pulse line_dropped, stay in SEARCH. The whole line is skipped.
  - ACTIVE: 11-bit byte counter runs 0..2*ACTIVE_PIXELS-1.
    - Odd counter values are Y bytes: data_out<=byte, write=1 in the next cycle (latency 1).
    - Even values (Cb/Cr): write=0.
    - After byte 2*ACTIVE_PIXELS-1 is sampled, go to SEARCH.
    - The following EAV is processed normally.
  - Premature code in ACTIVE (byte 0xFF sampled):
    - short_line pulses; the FF is not written.
    - Go to PAD with remaining = ACTIVE_PIXELS minus Y samples already written.
    - The detector continues with this FF as preamble byte 1.
  - PAD: write=1 and data_out=BLACK_Y every cycle until remaining reaches 0, then go to SEARCH.
    - An active SAV arriving during PAD pulses line_dropped and is not accepted.
    - EAV and vblank tracking continue during PAD.
- Write count invariant: exactly ACTIVE_PIXELS writes between a valid accepted SAV and the return to SEARCH, with no exceptions.
- A mid-line fifo_full change is ignored; the FIFO rejects writes itself.
- Byte 0x00 in active video is passed through as data; only 0xFF terminates a line.

Test Plan:
- Reset, then SAV FF 00 00 80 followed by 1440 bytes alternating Cb=0x80 and Y=0x01..: exactly 720 writes on alternate cycles, first data_out=0x01 one cycle after the Y byte, sav_pulse once, field=0, vblank=0.
- Blanking-line SAV FF 00 00 AB (V=1): sav_pulse, vblank=1, zero writes. Then EAV FF 00 00 9D (H=1, V=0): eav_pulse, vblank=0.
- XY=0x81 (bad protection bits) after the preamble: protect_err pulse, no sav_pulse, no writes, field/vblank unchanged.
- fifo_full=1 during the cycle SAV 0x80 is sampled: line_dropped pulse, zero writes for that line. The next SAV with fifo_full=0 is accepted normally.
- Active line cut by FF 00 00 9D after 200 Y samples: short_line pulse, then 520 consecutive writes of 0x10 (total 720), eav_pulse on the XY byte.
- Reset asserted after 300 Y writes: all outputs 0 asynchronously, no padding after release. The next SAV yields a full 720-write line.
